// File: rtl/mem_request_sequencer.sv
// Bus-side sequencer in front of the MAR/MDR/SRAM interface.
// Accepts one read or write at a time and sequences address, strobes and the
// shared data bus. Read data is returned with a one-cycle ack.
// Ports:
//   clk, nReset            clock, asynchronous active-low reset
//   req, reqWrite          request valid (sampled while idle), 1=write 0=read
//   reqAddr, reqData       request address and write data
//   busy, ack              in-flight indicator, one-cycle completion pulse
//   rdData                 last completed read result
//   memAdd                 address to the MAR
//   nMemWrite, nMemOut     active-low write strobe / output enable
//   memData                shared data bus, driven here only during writes
module mem_request_sequencer #(
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned ADDR_W        = 11,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              req,
  input  logic              reqWrite,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [DATA_W-1:0] reqData,
  output logic              busy,
  output logic              ack,
  output logic [DATA_W-1:0] rdData,
  output logic [ADDR_W-1:0] memAdd,
  output logic              nMemWrite,
  output logic              nMemOut,
  inout  wire  [DATA_W-1:0] memData
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ADDR, ACCESS, DONE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                is_write_q, is_write_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                drive_q, drive_d;
  logic                busy_q, busy_d;
  logic                ack_q, ack_d;
  logic [DATA_W-1:0]   rddata_q, rddata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                nwr_q, nwr_d;
  logic                noe_q, noe_d;

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_write_d = is_write_q;
    wdata_d    = wdata_q;
    drive_d    = drive_q;
    busy_d     = busy_q;
    ack_d      = 1'b0;
    rddata_d   = rddata_q;
    addr_d     = addr_q;
    nwr_d      = nwr_q;
    noe_d      = noe_q;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d    = ADDR;
          busy_d     = 1'b1;
          is_write_d = reqWrite;
          addr_d     = reqAddr;
          wdata_d    = reqData;
          // Write data goes on the bus already during the address cycle.
          drive_d    = reqWrite;
        end
      end
      ADDR: begin
        state_d = ACCESS;
        cnt_d   = '0;
        nwr_d   = ~is_write_q;
        noe_d   = is_write_q;
      end
      ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          nwr_d   = 1'b1;
          noe_d   = 1'b1;
          drive_d = 1'b0;
          ack_d   = 1'b1;
          if (!is_write_q) rddata_d = memData;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_write_q <= 1'b0;
      wdata_q    <= '0;
      drive_q    <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      rddata_q   <= '0;
      addr_q     <= '0;
      nwr_q      <= 1'b1;
      noe_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_write_q <= is_write_d;
      wdata_q    <= wdata_d;
      drive_q    <= drive_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      rddata_q   <= rddata_d;
      addr_q     <= addr_d;
      nwr_q      <= nwr_d;
      noe_q      <= noe_d;
    end
  end

  assign busy      = busy_q;
  assign ack       = ack_q;
  assign rdData    = rddata_q;
  assign memAdd    = addr_q;
  assign nMemWrite = nwr_q;
  assign nMemOut   = noe_q;
  assign memData   = drive_q ? wdata_q : {DATA_W{1'bz}};

endmodule
